// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder: state encoding, digit constants
// and the nine's-complement helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ       = 4'd6;

  // Invalid digits stay invalid after complementing, so err detection is unaffected.
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return 4'(BCD_DIGIT_MAX - d);
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand request / result handshake bundle for bcd_serial_add_ctrl.
interface bcd_serial_add_ctrl_if #(
  parameter int unsigned DIGITS = 8
);
  localparam int unsigned W = 4 * DIGITS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         Cout;
  logic         err;
  logic         busy;

  modport master (
    output in_valid, A, B, Cin, sub, out_ready,
    input  in_ready, out_valid, S, Cout, err, busy
  );

  modport slave (
    input  in_valid, A, B, Cin, sub, out_ready,
    output in_ready, out_valid, S, Cout, err, busy
  );

endinterface

// File: rtl/bcd_digit_pair_add.sv
// Combinational two-digit packed-BCD add slice with decimal carry and invalid-digit flag.
module bcd_digit_pair_add
  import bcd_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout,
  output logic       bad
);

  logic [4:0] t;
  logic       c;

  always_comb begin
    s   = '0;
    bad = 1'b0;
    t   = '0;
    c   = cin;
    for (int i = 0; i < 2; i++) begin
      t = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(c);
      // t > 9 also covers the 4-bit carry-out case (t >= 16)
      if (t > 5'(BCD_DIGIT_MAX)) begin
        s[4*i +: 4] = t[3:0] + BCD_ADJ;
        c           = 1'b1;
      end else begin
        s[4*i +: 4] = t[3:0];
        c           = 1'b0;
      end
      bad = bad | (a[4*i +: 4] > BCD_DIGIT_MAX) | (b[4*i +: 4] > BCD_DIGIT_MAX);
    end
    cout = c;
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that walks one shared 2-digit slice over the operands, LSB pair first.
// Optional subtract mode (nine's complement of B, forced carry-in) is enabled by defining BCD_SUB_EN.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 8
) (
  input logic                  clk,
  input logic                  rst,
  bcd_serial_add_ctrl_if.slave bus
);

  localparam int unsigned PAIRS = DIGITS / 2;
  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAIRS - 1);

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     s_q;
  logic             carry;
  logic             cout_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [IDX_W-1:0] idx;

  logic [W-1:0]     b_eff;
  logic             cin_eff;
  logic [7:0]       pair_s;
  logic             pair_cout;
  logic             pair_bad;

  // Operand B and carry-in as they will be latched at capture
  always_comb begin
    b_eff   = bus.B;
    cin_eff = bus.Cin;
`ifdef BCD_SUB_EN
    if (bus.sub) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        b_eff[4*i +: 4] = nines_comp(bus.B[4*i +: 4]);
      end
      cin_eff = 1'b1;
    end
`else
    // Add-only build: sub is accepted on the interface but has no effect.
`endif
  end

  bcd_digit_pair_add u_pair (
    .a    (a_q[8*idx +: 8]),
    .b    (b_q[8*idx +: 8]),
    .cin  (carry),
    .s    (pair_s),
    .cout (pair_cout),
    .bad  (pair_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      carry       <= 1'b0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      idx         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.A;
            b_q        <= b_eff;
            carry      <= cin_eff;
            idx        <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          s_q[8*idx +: 8] <= pair_s;
          carry           <= pair_cout;
          err_q           <= err_q | pair_bad;
          if (idx == IDX_LAST) begin
            cout_q      <= pair_cout;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: decimal-arithmetic reference model with a per-cycle compare
// process, plus literal expectations pinned for the directed vectors.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned PAIRS  = DIGITS / 2;
  localparam int unsigned W      = 4 * DIGITS;

  logic clk;
  logic rst;

  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Literal expectations for the next result, set by the stimulus process.
  bit           lit_on;
  bit           lit_s_on;
  logic [W-1:0] lit_s;
  logic         lit_co;
  logic         lit_err;
  bit           tmo_flag;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain decimal arithmetic on the operand values.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic sb, output logic [W-1:0] s, output logic co,
                                output logic er);
    longint av, bv, p, r;
    longint da, db;
    av = 0; bv = 0; p = 1; er = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      da = longint'(a[4*i +: 4]);
      db = longint'(b[4*i +: 4]);
      if (da > 9 || db > 9) er = 1'b1;
      av += da * p;
      bv += db * p;
      p  *= 10;
    end
`ifdef BCD_SUB_EN
    if (sb) begin
      if (av >= bv) begin r = av - bv;          co = 1'b1; end
      else          begin r = p - (bv - av);    co = 1'b0; end
    end else begin
      r  = av + bv + longint'(cin);
      co = (r >= p);
      r  = r % p;
    end
`else
    r  = av + bv + longint'(cin);
    co = (r >= p);
    r  = r % p;
    if (sb) r = r;
`endif
    s = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      s[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  typedef enum int {M_NONE, M_IDLE, M_RUN, M_DONE} mph_t;
  mph_t         ph = M_NONE;
  int           ncnt = 0;
  int           due;
  bit           chk_reset = 0;
  logic [W-1:0] exp_s;
  logic         exp_co;
  logic         exp_err;

  // Compare process: every negedge, checks DUT outputs against the behavioural model.
  always @(negedge clk) begin
    ncnt++;
    chk("no_timeout", 64'(tmo_flag), 64'(0));
    if (chk_reset) begin
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_S", 64'(bus.S), 64'(0));
      chk("rst_Cout", 64'(bus.Cout), 64'(0));
      chk("rst_err", 64'(bus.err), 64'(0));
    end
    case (ph)
      M_IDLE: begin
        chk("idle_in_ready", 64'(bus.in_ready), 64'(1));
        chk("idle_out_valid", 64'(bus.out_valid), 64'(0));
        chk("idle_busy", 64'(bus.busy), 64'(0));
        if (bus.in_valid && !rst) begin
          model(bus.A, bus.B, bus.Cin, bus.sub, exp_s, exp_co, exp_err);
          due = ncnt + int'(PAIRS) + 1;
          ph  = M_RUN;
        end
      end
      M_RUN: begin
        if (ncnt < due) begin
          chk("run_out_valid", 64'(bus.out_valid), 64'(0));
          chk("run_in_ready", 64'(bus.in_ready), 64'(0));
          chk("run_busy", 64'(bus.busy), 64'(1));
        end else begin
          chk("latency_out_valid", 64'(bus.out_valid), 64'(1));
          if (!exp_err) begin
            chk("first_S", 64'(bus.S), 64'(exp_s));
            chk("first_Cout", 64'(bus.Cout), 64'(exp_co));
          end
          chk("first_err", 64'(bus.err), 64'(exp_err));
          if (lit_on) begin
            if (lit_s_on) begin
              chk("lit_S", 64'(bus.S), 64'(lit_s));
              chk("lit_Cout", 64'(bus.Cout), 64'(lit_co));
            end
            chk("lit_err", 64'(bus.err), 64'(lit_err));
          end
          ph = M_DONE;
        end
      end
      M_DONE: begin
        chk("done_out_valid", 64'(bus.out_valid), 64'(1));
        chk("done_in_ready", 64'(bus.in_ready), 64'(0));
        chk("done_busy", 64'(bus.busy), 64'(1));
        if (!exp_err) begin
          chk("hold_S", 64'(bus.S), 64'(exp_s));
          chk("hold_Cout", 64'(bus.Cout), 64'(exp_co));
        end
        chk("hold_err", 64'(bus.err), 64'(exp_err));
      end
      default: ;
    endcase
    if (ph == M_DONE && bus.out_ready) ph = M_IDLE;
    chk_reset = rst;
    if (rst) ph = M_IDLE;
  end

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(DIGITS); i++) v[4*i +: 4] = 4'($urandom_range(9));
    return v;
  endfunction

  task automatic set_lit(input bit on, input bit s_on, input logic [W-1:0] s,
                         input logic co, input logic er);
    lit_on = on; lit_s_on = s_on; lit_s = s; lit_co = co; lit_err = er;
  endtask

  // One operation: present operands for one cycle, wait for the result, hold, then accept.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sb, input int hold, input bit noise);
    bit seen;
    @(posedge clk); #1;
    bus.A = a; bus.B = b; bus.Cin = cin; bus.sub = sb; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    if (!seen) tmo_flag = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (noise) begin
        bus.in_valid = ~bus.in_valid;
        bus.A        = W'($urandom);
        bus.B        = W'($urandom);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    tmo_flag = 1'b0;
    set_lit(0, 0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    set_lit(1, 1, 32'h0000_0000, 1'b1, 1'b0);
    run_op(32'h9999_9999, 32'h0000_0001, 1'b0, 1'b0, 0, 0);
    set_lit(1, 1, 32'h0000_0000, 1'b1, 1'b0);
    run_op(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 0, 0);
    set_lit(1, 1, 32'h9999_9999, 1'b0, 1'b0);
    run_op(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 0, 0);

    // Consumer stall with ignored in_valid traffic
    set_lit(1, 1, 32'h0006_6666, 1'b0, 1'b0);
    run_op(32'h0001_2345, 32'h0005_4321, 1'b0, 1'b0, 10, 1);

    // Invalid digit, then a clean op must clear err
    set_lit(1, 0, '0, 1'b0, 1'b1);
    run_op(32'h0000_000A, 32'h0000_0000, 1'b0, 1'b0, 0, 0);
    set_lit(1, 1, 32'h0000_0009, 1'b0, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0004, 1'b0, 1'b0, 0, 0);

    set_lit(0, 0, '0, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(1)), 1'b0, n, 0);

    // Reset during the second RUN cycle discards the operation
    @(posedge clk); #1;
    bus.A = 32'h1111_1111; bus.B = 32'h2222_2222; bus.Cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);

    set_lit(1, 1, 32'h0000_0000, 1'b1, 1'b0);
    run_op(32'h5000_0000, 32'h5000_0000, 1'b0, 1'b0, 0, 0);

`ifdef BCD_SUB_EN
    set_lit(1, 1, 32'h0000_0099, 1'b1, 1'b0);
    run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 0, 0);
    set_lit(1, 1, 32'h9999_9999, 1'b0, 1'b0);
    run_op(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 0, 0);
    set_lit(0, 0, '0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) run_op(rand_bcd(), rand_bcd(), 1'b0, 1'b1, 0, 0);
`endif

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
